// File: rtl/lenet_layer_engine.sv
// lenet_layer_engine
//   Sequential LeNet layer engine. A single instance runs either a KxK
//   single-channel convolution with bias (mode 0) or a 2x2 max-pool (mode 1)
//   over an IMG_W x IMG_H image held in an internal RAM. Image and
//   coefficients arrive over valid/ready streams; results leave in raster
//   order over a valid/ready stream.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       synchronous active-low reset
//     start_i      start a layer (sampled in IDLE only)
//     mode_i       0 = conv, 1 = 2x2 max-pool (latched on the accepted start)
//     busy_o       layer in progress
//     done_o       one-cycle pulse after the last result handshake
//     pix_valid_i  / pix_data_i / pix_ready_o   image stream, raster order
//     wgt_valid_i  / wgt_data_i / wgt_ready_o   K*K weights then one bias word
//     res_valid_o  / res_data_o / res_ready_i   signed ACC_W results
module lenet_layer_engine #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  input  logic              wgt_valid_i,
  input  logic [DATA_W-1:0] wgt_data_i,
  output logic              wgt_ready_o,
  output logic              res_valid_o,
  output logic [ACC_W-1:0]  res_data_o,
  input  logic              res_ready_i
);

  localparam int PIX_N  = IMG_W * IMG_H;
  localparam int WGT_N  = K * K;
  localparam int PA_W   = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int WA_W   = (WGT_N > 1) ? $clog2(WGT_N) : 1;
  localparam int CC_W   = $clog2(WGT_N + 1);
  localparam int X_W    = $clog2(IMG_W + 1);
  localparam int Y_W    = $clog2(IMG_H + 1);
  localparam int KW_W   = $clog2(K + 1);
  localparam int PROD_W = 2 * DATA_W;

  localparam int CONV_X_LAST = IMG_W - K;
  localparam int CONV_Y_LAST = IMG_H - K;
  localparam int POOL_X_LAST = IMG_W / 2 - 1;
  localparam int POOL_Y_LAST = IMG_H / 2 - 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_IMG  = 3'd1;
  localparam logic [2:0] S_LOAD_COEF = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_OUTPUT    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  function automatic logic signed [ACC_W-1:0] sext_data(input logic signed [DATA_W-1:0] v);
    return ACC_W'(v);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] v);
    return ACC_W'(v);
  endfunction

  function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Storage (never reset: contents are reloaded by every layer)
  logic signed [DATA_W-1:0] img_mem [PIX_N];
  logic signed [DATA_W-1:0] wgt_mem [WGT_N];

  // Control state
  logic [2:0]      state_q,    state_d;
  logic            mode_q,     mode_d;
  logic [PA_W-1:0] pix_cnt_q,  pix_cnt_d;
  logic [CC_W-1:0] coef_cnt_q, coef_cnt_d;
  logic [X_W-1:0]  out_x_q,    out_x_d;
  logic [Y_W-1:0]  out_y_q,    out_y_d;
  logic [KW_W-1:0] win_x_q,    win_x_d;
  logic [KW_W-1:0] win_y_q,    win_y_d;

  // Datapath state
  logic signed [ACC_W-1:0]  acc_q,  acc_d;
  logic signed [ACC_W-1:0]  res_q,  res_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;

  logic                     pix_hs, wgt_hs;
  logic                     coef_is_bias;
  logic [31:0]              stride;
  logic [PA_W-1:0]          rd_addr;
  logic [WA_W-1:0]          wgt_rd_idx, coef_wr_idx;
  logic signed [DATA_W-1:0] rd_pix, rd_wgt;
  logic signed [PROD_W-1:0] prod;
  logic                     win_first, win_x_end, win_y_end, out_x_end, out_y_end;
  logic [KW_W-1:0]          win_lim;
  logic signed [ACC_W-1:0]  acc_base, mac_sum, pix_ext, pool_max, acc_next, conv_res;

  assign busy_o      = (state_q == S_LOAD_IMG) || (state_q == S_LOAD_COEF) ||
                       (state_q == S_COMPUTE)  || (state_q == S_OUTPUT);
  assign done_o      = (state_q == S_DONE);
  assign pix_ready_o = (state_q == S_LOAD_IMG);
  assign wgt_ready_o = (state_q == S_LOAD_COEF);
  assign res_valid_o = (state_q == S_OUTPUT);
  assign res_data_o  = res_q;

  assign pix_hs       = pix_valid_i && pix_ready_o;
  assign wgt_hs       = wgt_valid_i && wgt_ready_o;
  assign coef_is_bias = (coef_cnt_q == CC_W'(WGT_N));
  assign coef_wr_idx  = WA_W'(coef_cnt_q);

  // Window address: conv slides by 1 pixel per output, pool by 2.
  assign stride     = mode_q ? 32'd2 : 32'd1;
  assign rd_addr    = PA_W'((32'(out_y_q) * stride + 32'(win_y_q)) * 32'(IMG_W) +
                            32'(out_x_q) * stride + 32'(win_x_q));
  assign wgt_rd_idx = WA_W'(32'(win_y_q) * 32'(K) + 32'(win_x_q));
  assign rd_pix     = img_mem[rd_addr];
  assign rd_wgt     = wgt_mem[wgt_rd_idx];

  assign win_lim   = mode_q ? KW_W'(1) : KW_W'(K - 1);
  assign win_first = (win_x_q == '0) && (win_y_q == '0);
  assign win_x_end = (win_x_q == win_lim);
  assign win_y_end = (win_y_q == win_lim);
  assign out_x_end = (out_x_q == (mode_q ? X_W'(POOL_X_LAST) : X_W'(CONV_X_LAST)));
  assign out_y_end = (out_y_q == (mode_q ? Y_W'(POOL_Y_LAST) : Y_W'(CONV_Y_LAST)));

  // The first window element restarts the accumulation, so no separate clear cycle.
  assign prod     = PROD_W'(rd_pix) * PROD_W'(rd_wgt);
  assign acc_base = win_first ? '0 : acc_q;
  assign mac_sum  = acc_base + sext_prod(prod);
  assign pix_ext  = sext_data(rd_pix);
  assign pool_max = win_first ? pix_ext : smax(acc_q, pix_ext);
  assign acc_next = mode_q ? pool_max : mac_sum;
  assign conv_res = acc_next + sext_data(bias_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pix_cnt_d  = pix_cnt_q;
    coef_cnt_d = coef_cnt_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    acc_d      = acc_q;
    res_d      = res_q;
    bias_d     = bias_q;

    if (wgt_hs && coef_is_bias) begin
      bias_d = $signed(wgt_data_i);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_LOAD_IMG;
          mode_d    = mode_i;
          pix_cnt_d = '0;
        end
      end
      S_LOAD_IMG: begin
        if (pix_hs) begin
          if (pix_cnt_q == PA_W'(PIX_N - 1)) begin
            pix_cnt_d  = '0;
            coef_cnt_d = '0;
            out_x_d    = '0;
            out_y_d    = '0;
            win_x_d    = '0;
            win_y_d    = '0;
            state_d    = mode_q ? S_COMPUTE : S_LOAD_COEF;
          end else begin
            pix_cnt_d = pix_cnt_q + PA_W'(1);
          end
        end
      end
      S_LOAD_COEF: begin
        if (wgt_hs) begin
          if (coef_is_bias) begin
            state_d = S_COMPUTE;
          end else begin
            coef_cnt_d = coef_cnt_q + CC_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        acc_d = acc_next;
        if (win_x_end) begin
          win_x_d = '0;
          if (win_y_end) begin
            win_y_d = '0;
            res_d   = mode_q ? acc_next : conv_res;
            state_d = S_OUTPUT;
          end else begin
            win_y_d = win_y_q + KW_W'(1);
          end
        end else begin
          win_x_d = win_x_q + KW_W'(1);
        end
      end
      S_OUTPUT: begin
        if (res_ready_i) begin
          if (out_x_end) begin
            out_x_d = '0;
            if (out_y_end) begin
              state_d = S_DONE;
            end else begin
              out_y_d = out_y_q + Y_W'(1);
              state_d = S_COMPUTE;
            end
          end else begin
            out_x_d = out_x_q + X_W'(1);
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // res_q is reset because it drives res_data_o directly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      pix_cnt_q  <= '0;
      coef_cnt_q <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pix_cnt_q  <= pix_cnt_d;
      coef_cnt_q <= coef_cnt_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      res_q      <= res_d;
    end
  end

  always_ff @(posedge clk_i) begin
    acc_q  <= acc_d;
    bias_q <= bias_d;
    if (pix_hs) begin
      img_mem[pix_cnt_q] <= $signed(pix_data_i);
    end
    if (wgt_hs && !coef_is_bias) begin
      wgt_mem[coef_wr_idx] <= $signed(wgt_data_i);
    end
  end

endmodule

// File: tb/tb_lenet_layer_engine.sv
`timescale 1ns/1ps
module tb_lenet_layer_engine;

  localparam int DATA_W = 8;
  localparam int IW     = 6;
  localparam int IH     = 6;
  localparam int K      = 3;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic              pix_valid = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              wgt_valid = 1'b0;
  logic [DATA_W-1:0] wgt_data = '0;
  logic              res_ready = 1'b0;
  logic              busy, done, pix_ready, wgt_ready, res_valid;
  logic [ACC_W-1:0]  res_data;

  lenet_layer_engine #(
    .DATA_W(DATA_W), .IMG_W(IW), .IMG_H(IH), .K(K), .ACC_W(ACC_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done),
    .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
    .wgt_valid_i(wgt_valid), .wgt_data_i(wgt_data), .wgt_ready_o(wgt_ready),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_ready_i(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference data and scoreboard
  int img [IW*IH];
  int wgt [K*K];
  int bias;
  int exp_q [$];

  // Shared with the monitor
  bit          mon_en = 1'b0;
  int          run_id = 0;
  bit          cur_mode = 1'b0;
  int          first_ref_cyc = 0;
  int          seen_run = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          hold_cnt = 0;
  int          wgt_viol = 0;
  int          ref_cyc = 0;
  bit          fresh = 1'b1;
  bit          hold_pending = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string nm, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Behavioural reference: direct definition of convolution and max-pool.
  task automatic push_model(input bit m);
    if (!m) begin
      for (int oy = 0; oy <= IH - K; oy++)
        for (int ox = 0; ox <= IW - K; ox++) begin
          int s;
          s = bias;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              s += img[(oy + i) * IW + ox + j] * wgt[i * K + j];
          exp_q.push_back(s);
        end
    end else begin
      for (int oy = 0; oy < IH / 2; oy++)
        for (int ox = 0; ox < IW / 2; ox++) begin
          int mx;
          mx = img[2 * oy * IW + 2 * ox];
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              if (img[(2 * oy + i) * IW + 2 * ox + j] > mx) mx = img[(2 * oy + i) * IW + 2 * ox + j];
          exp_q.push_back(mx);
        end
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (run_id != seen_run) begin
          seen_run     = run_id;
          hs_cnt       = 0;
          done_cnt     = 0;
          hold_cnt     = 0;
          wgt_viol     = 0;
          fresh        = 1'b1;
          hold_pending = 1'b0;
        end
        if (hold_pending) begin
          check("hold_valid", res_valid, 1);
          check("hold_data", int'(res_data), int'(held));
          hold_cnt++;
          hold_pending = 1'b0;
        end
        if (res_valid) begin
          if (fresh) begin
            check($sformatf("latency[%0d]", hs_cnt), cyc,
                  (hs_cnt == 0 ? first_ref_cyc : ref_cyc) + (cur_mode ? 4 : K * K));
            fresh = 1'b0;
          end
          if (res_ready) begin
            if (exp_q.size() > 0) begin
              int e;
              e = exp_q.pop_front();
              check($sformatf("result[%0d]", hs_cnt), int'(res_data), e);
            end else begin
              check("extra_result", int'(res_data), -1);
            end
            hs_cnt++;
            fresh   = 1'b1;
            ref_cyc = cyc + 1;
          end else begin
            hold_pending = 1'b1;
            held         = res_data;
          end
        end
        if (done) begin
          done_cnt++;
          check("done_busy_low", busy, 0);
        end
        if (cur_mode && wgt_ready) wgt_viol++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_wgt_ready"}, wgt_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  task automatic send_word(input bit coef, input int d, input bit gaps);
    bit rdy;
    int guard;
    rdy   = 1'b0;
    guard = 0;
    if (gaps) begin
      while (($urandom % 4) == 0) begin
        start = 1'($urandom % 2);
        mode  = 1'($urandom % 2);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (coef) begin
      wgt_valid = 1'b1;
      wgt_data  = 8'(d);
    end else begin
      pix_valid = 1'b1;
      pix_data  = 8'(d);
    end
    do begin
      @(negedge clk);
      rdy = coef ? wgt_ready : pix_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 100);
    pix_valid = 1'b0;
    wgt_valid = 1'b0;
    pix_data  = 8'($urandom);
    wgt_data  = 8'($urandom);
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_handshake: ready=%0d after %0d cycles, required 1", rdy, guard);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "load stalled");
    end
  endtask

  // pol: 0 = always ready, 1 = random ready, 2 = 10-cycle stall on result 5
  task automatic run_layer(input bit m, input bit gaps, input int pol);
    int n_exp, guard, stall_left;
    push_model(m);
    n_exp    = exp_q.size();
    cur_mode = m;
    run_id++;
    mon_en    = 1'b1;
    res_ready = 1'b1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom % 2);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < IW * IH; i++) send_word(1'b0, img[i], gaps);
    check("wgt_ready_after_image", wgt_ready, m ? 0 : 1);
    if (!m) begin
      for (int i = 0; i < K * K; i++) send_word(1'b1, wgt[i], gaps);
      send_word(1'b1, bias, gaps);
    end
    start = 1'b0;
    first_ref_cyc = cyc;
    stall_left = 10;
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      case (pol)
        1: res_ready = (($urandom % 3) != 0);
        2: begin
          if (hs_cnt == 4 && stall_left > 0) begin
            res_ready = 1'b0;
            if (res_valid) stall_left--;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", guard < 5000, 1);
    res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("done_pulses", done_cnt, 1);
    check("result_count", hs_cnt, n_exp);
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    if (pol == 2) check("stall_hold_cycles", hold_cnt, 10);
    if (m) check("wgt_ready_in_pool", wgt_viol, 0);
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL global_timeout: simulation time exceeded");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      start     = 1'($urandom % 2);
      mode      = 1'($urandom % 2);
      pix_valid = 1'($urandom % 2);
      pix_data  = 8'($urandom);
      wgt_valid = 1'($urandom % 2);
      wgt_data  = 8'($urandom);
      res_ready = 1'($urandom % 2);
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b0; wgt_valid = 1'b0; res_ready = 1'b1;
    rst_n = 1'b1;

    // Conv, all ones, bias 2
    foreach (img[i]) img[i] = 1;
    foreach (wgt[i]) wgt[i] = 1;
    bias = 2;
    run_layer(1'b0, 1'b0, 0);

    // Conv, negative pixels, bias -128
    foreach (img[i]) img[i] = -1;
    foreach (wgt[i]) wgt[i] = 2;
    bias = -128;
    run_layer(1'b0, 1'b0, 0);

    // Pool on a ramp
    foreach (img[i]) img[i] = i;
    run_layer(1'b1, 1'b0, 0);

    // Conv with a stall on result 5
    foreach (img[i]) img[i] = 1;
    foreach (wgt[i]) wgt[i] = 1;
    bias = 2;
    run_layer(1'b0, 1'b0, 2);

    // Reset during COMPUTE, then rerun the pool layer
    foreach (img[i]) img[i] = i;
    mon_en = 1'b0;
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < IW * IH; i++) send_word(1'b0, img[i], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", busy, 0);
    @(posedge clk); #1;
    run_layer(1'b1, 1'b0, 0);

    // Randomized layers with gaps and random back-pressure
    for (int r = 0; r < 8; r++) begin
      bit m;
      foreach (img[i]) img[i] = int'($urandom_range(0, 255)) - 128;
      foreach (wgt[i]) wgt[i] = int'($urandom_range(0, 255)) - 128;
      bias = int'($urandom_range(0, 255)) - 128;
      m = 1'($urandom % 2);
      run_layer(m, 1'b1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
